// File: rtl/iso14443a_tag_modulator.sv
// iso14443a_tag_modulator: tag-side ISO14443-A Manchester/subcarrier load-modulation transmitter
module iso14443a_tag_modulator #(
  parameter int BIT_PERIOD  = 128,
  parameter int SUBC_PERIOD = 16
) (
  input  logic       osc_clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic [3:0] tx_nbits,
  input  logic       tx_last,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       mod_out,
  output logic       busy,
  output logic       underrun
);
  localparam int CW = $clog2(BIT_PERIOD);
  localparam int SW = $clog2(SUBC_PERIOD);
  typedef enum logic [2:0] {IDLE, SOF, DATA, PAR, EOF} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic hfull_q, hfull_d, hlast_q, hlast_d, last_q, last_d;
  logic [7:0] hdata_q, hdata_d, sh_q, sh_d, byte_q, byte_d;
  logic [3:0] hnb_q, hnb_d, nb_q, nb_d, idx_q, idx_d;
  logic mod_out_d, busy_d, underrun_d;
  logic wrap, end_byte, load, bit_v, act;
  assign tx_ready = ~hfull_q;
  always_comb begin
    wrap = cnt_q == CW'(BIT_PERIOD - 1);
    end_byte = wrap && ((state_q == DATA && idx_q == nb_q - 4'd1 && nb_q != 4'd8) || state_q == PAR);
    load = (wrap && state_q == SOF) || (end_byte && !last_q && hfull_q);
    state_d = state_q;
    sh_d = sh_q;
    byte_d = byte_q;
    nb_d = nb_q;
    idx_d = idx_q;
    last_d = last_q;
    if (wrap)
      case (state_q)
        IDLE: state_d = hfull_q ? SOF : IDLE;
        SOF:  state_d = DATA;
        DATA: begin
          state_d = (idx_q != nb_q - 4'd1) ? DATA : (nb_q == 4'd8) ? PAR : load ? DATA : EOF;
          idx_d = idx_q + 4'd1;
          sh_d = sh_q >> 1;
        end
        PAR:  state_d = load ? DATA : EOF;
        default: state_d = IDLE;
      endcase
    if (load) begin
      sh_d = hdata_q;
      byte_d = hdata_q;
      nb_d = hnb_q;
      last_d = hlast_q;
      idx_d = 4'd0;
    end
    // load needs a full holding register and accept needs an empty one, so they never collide
    hfull_d = load ? 1'b0 : hfull_q;
    hdata_d = hdata_q;
    hnb_d = hnb_q;
    hlast_d = hlast_q;
    if (tx_valid && !hfull_q) begin
      hfull_d = 1'b1;
      hdata_d = tx_data;
      hnb_d = (tx_nbits == 4'd0 || tx_nbits > 4'd8) ? 4'd8 : tx_nbits;
      hlast_d = tx_last;
    end
    underrun_d = end_byte && !last_q && !hfull_q;
    act = state_q == SOF || state_q == DATA || state_q == PAR;
    bit_v = (state_q == DATA) ? sh_q[0] : (state_q == PAR) ? ~^byte_q : 1'b1;
    mod_out_d = act && (bit_v ^ cnt_q[CW-1]) && !cnt_q[SW-1];
    busy_d = state_d != IDLE;
  end
  always_ff @(negedge osc_clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      hfull_q <= 1'b0;
      mod_out <= 1'b0;
      busy <= 1'b0;
      underrun <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_q + CW'(1);
      hfull_q <= hfull_d;
      mod_out <= mod_out_d;
      busy <= busy_d;
      underrun <= underrun_d;
    end
    hdata_q <= hdata_d;
    hnb_q <= hnb_d;
    hlast_q <= hlast_d;
    sh_q <= sh_d;
    byte_q <= byte_d;
    nb_q <= nb_d;
    idx_q <= idx_d;
    last_q <= last_d;
  end
endmodule

// File: tb/tb_iso14443a_tag_modulator.sv
// tb_iso14443a_tag_modulator: symbol-queue reference model plus directed and random frames
module tb_iso14443a_tag_modulator;
  localparam int BP = 128;
  logic osc_clk = 0, rst = 1;
  logic [7:0] tx_data = 0;
  logic [3:0] tx_nbits = 8;
  logic tx_last = 0, tx_valid = 0;
  logic tx_ready, mod_out, busy, underrun;
  always #5 osc_clk = ~osc_clk;

  iso14443a_tag_modulator dut (
    .osc_clk(osc_clk), .rst(rst), .tx_data(tx_data), .tx_nbits(tx_nbits), .tx_last(tx_last),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .mod_out(mod_out), .busy(busy), .underrun(underrun)
  );

  typedef struct {logic [7:0] d; int n; logic l;} byte_t;
  byte_t hold[$];
  int syms[$];
  int cur = -1;
  int m_cnt = 0;
  logic mlast = 0, m_on = 0;
  logic e_mod = 0, e_busy = 0, e_under = 0, e_ready = 1;

  // cur: -1 idle, 0/1 symbol on air (SOF is a 1), 2 EOF
  always @(negedge osc_clk) begin
    logic acc;
    byte_t b;
    if (rst) begin
      hold.delete();
      syms.delete();
      cur = -1;
      m_cnt = 0;
      e_mod = 0; e_busy = 0; e_under = 0; e_ready = 1;
      m_on = 1;
    end else begin
      acc = tx_valid && hold.size() == 0;
      e_mod = (cur == 0 || cur == 1) && ((cur == 1) == (m_cnt < BP / 2)) && (m_cnt % 16 < 8);
      e_under = 0;
      if (m_cnt == BP - 1) begin
        if (cur == -1) begin
          if (hold.size() > 0) begin cur = 1; mlast = 0; end
        end else if (cur == 2) cur = -1;
        else if (syms.size() > 0) cur = syms.pop_front();
        else if (mlast) cur = 2;
        else if (hold.size() == 0) begin e_under = 1; cur = 2; end
        else begin
          b = hold.pop_front();
          mlast = b.l;
          for (int i = 0; i < b.n; i++) syms.push_back(int'(b.d[i]));
          if (b.n == 8) syms.push_back(int'(~^b.d));
          cur = syms.pop_front();
        end
      end
      if (acc) begin
        b.d = tx_data;
        b.n = (tx_nbits == 0 || tx_nbits > 8) ? 8 : int'(tx_nbits);
        b.l = tx_last;
        hold.push_back(b);
      end
      m_cnt = (m_cnt + 1) % BP;
      e_busy = cur != -1;
      e_ready = hold.size() == 0;
    end
  end

  int checks = 0, errors = 0;
  int n_busy = 0, n_mod = 0, n_under = 0;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", nm, a, e, $time);
    end
  endtask

  task automatic cmp_loop();
    forever begin
      @(posedge osc_clk);
      if (m_on) begin
        chk("mod_out", 32'(mod_out), 32'(e_mod));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("underrun", 32'(underrun), 32'(e_under));
        chk("tx_ready", 32'(tx_ready), 32'(e_ready));
        n_busy += int'(busy);
        n_mod += int'(mod_out);
        n_under += int'(underrun);
      end
    end
  endtask

  task automatic send(input logic [7:0] d, input logic [3:0] n, input logic l, input bit hold_v);
    int t = 0;
    tx_data = d; tx_nbits = n; tx_last = l; tx_valid = 1;
    while (!tx_ready && t < 6000) begin @(posedge osc_clk); t++; end
    chk("send_timeout", 32'(t < 6000), 1);
    @(posedge osc_clk);
    if (!hold_v) begin tx_valid = 0; tx_data = 8'($urandom); tx_nbits = 4'($urandom); end
  endtask

  task automatic wait_done();
    int t = 0;
    @(posedge osc_clk);
    while ((busy || !tx_ready) && t < 8000) begin @(posedge osc_clk); t++; end
    chk("done_timeout", 32'(t < 8000), 1);
  endtask

  task automatic frame_chk(input string nm, input int b0, input int m0, input int u0,
                           input int eb, input int em, input int eu);
    chk({nm, "_busy"}, n_busy - b0, eb);
    chk({nm, "_mod"}, n_mod - m0, em);
    chk({nm, "_under"}, n_under - u0, eu);
  endtask

  initial begin
    int b0, m0, u0, t;
    fork cmp_loop(); join_none
    repeat (3) @(posedge osc_clk);
    chk("reset_ready", 32'(tx_ready), 1);
    chk("reset_mod", 32'(mod_out), 0);
    rst = 0;
    repeat (5) @(posedge osc_clk);
    b0 = n_busy; m0 = n_mod; u0 = n_under;
    send(8'h01, 8, 1, 0);
    wait_done();
    frame_chk("t1", b0, m0, u0, 11 * BP, 10 * 32, 0);
    b0 = n_busy; m0 = n_mod; u0 = n_under;
    send(8'h04, 8, 0, 0);
    send(8'h00, 8, 1, 0);
    wait_done();
    frame_chk("t2", b0, m0, u0, 20 * BP, 19 * 32, 0);
    b0 = n_busy; m0 = n_mod; u0 = n_under;
    send(8'h0A, 4, 1, 0);
    wait_done();
    frame_chk("t3", b0, m0, u0, 6 * BP, 5 * 32, 0);
    b0 = n_busy; m0 = n_mod; u0 = n_under;
    send(8'h5A, 8, 0, 0);
    wait_done();
    frame_chk("t4", b0, m0, u0, 11 * BP, 10 * 32, 1);
    chk("t4_ready", 32'(tx_ready), 1);
    send(8'hA5, 8, 0, 0);
    t = 0;
    while (!tx_ready && t < 500) begin @(posedge osc_clk); t++; end
    send(8'h3C, 8, 1, 0);
    t = 0;
    while (!mod_out && t < 500) begin @(posedge osc_clk); t++; end
    chk("t5_mod_seen", 32'(mod_out), 1);
    chk("t5_held", 32'(tx_ready), 0);
    rst = 1;
    @(posedge osc_clk);
    chk("t5_mod", 32'(mod_out), 0);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_ready", 32'(tx_ready), 1);
    rst = 0;
    b0 = n_busy;
    repeat (300) @(posedge osc_clk);
    chk("t5_discard", n_busy - b0, 0);
    b0 = n_busy; m0 = n_mod; u0 = n_under;
    send(8'h11, 8, 0, 1);
    send(8'h22, 3, 0, 1);
    send(8'h33, 8, 1, 0);
    wait_done();
    frame_chk("t6", b0, m0, u0, 23 * BP, 22 * 32, 0);
    for (int f = 0; f < 12; f++) begin
      int nb;
      nb = 1 + int'($urandom % 3);
      for (int i = 0; i < nb; i++)
        send(8'($urandom), 4'($urandom), (i == nb - 1) && ($urandom % 4 != 0),
             (i != nb - 1) && $urandom % 2 == 1);
      wait_done();
      repeat ($urandom % 200) @(posedge osc_clk);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
